// File: rtl/axi4_m_burst_reader.sv
// AXI4 read master: splits a (address, beat count) command into INCR bursts that never cross 4 KB.
// Optional statistics counters are enabled by defining AXI4_RD_STATS_EN.
module axi4_m_burst_reader #(
    parameter int unsigned ADDRESS_SIZE  = 32,
    parameter int unsigned DATA_SIZE     = 32,
    parameter int unsigned MAX_BURST_LEN = 16,
    parameter int unsigned LEN_SIZE      = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ADDRESS_SIZE-1:0] cmd_addr,
    input  logic [LEN_SIZE-1:0]     cmd_len,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    output logic [ADDRESS_SIZE-1:0] m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_SIZE-1:0]    m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    output logic [DATA_SIZE-1:0]    m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic                    busy,
    output logic                    done,
    output logic                    err
`ifdef AXI4_RD_STATS_EN
    ,
    output logic [31:0]             stat_beats,
    output logic [31:0]             stat_bursts,
    output logic [31:0]             stat_stall
`endif
);

    localparam logic [2:0] ARSIZE = 3'($clog2(DATA_SIZE / 8));
    localparam logic [ADDRESS_SIZE-1:0] AMASK = ~(ADDRESS_SIZE'(DATA_SIZE / 8 - 1));
    localparam int unsigned BW = (LEN_SIZE > 13) ? LEN_SIZE : 13;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
    logic [LEN_SIZE-1:0]     left_q, left_d;
    logic [7:0]              arlen_q, arlen_d;
    logic                    acc_q, acc_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [DATA_SIZE-1:0]    tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;

    logic [ADDRESS_SIZE-1:0] cmd_addr_al;
    logic [8:0]              blen;
    logic                    ar_hs;
    logic                    r_hs;

    // Beats for the next burst: bounded by remaining beats, MAX_BURST_LEN and room left in the 4 KB page.
    function automatic logic [8:0] calc_blen(input logic [11:0] a, input logic [LEN_SIZE-1:0] left);
        logic [12:0]   room;
        logic [BW-1:0] m;
        room = (13'h1000 - {1'b0, a}) >> ARSIZE;
        m    = BW'(left);
        if (m > BW'(MAX_BURST_LEN)) m = BW'(MAX_BURST_LEN);
        if (m > BW'(room))          m = BW'(room);
        return m[8:0];
    endfunction

    assign cmd_addr_al   = cmd_addr & AMASK;
    assign blen          = {1'b0, arlen_q} + 9'd1;
    assign cmd_ready     = (state_q == IDLE);
    assign m_axi_arvalid = (state_q == ADDR);
    assign m_axi_rready  = (state_q == DATA) && (!tvalid_q || m_axis_tready);
    assign ar_hs         = m_axi_arvalid && m_axi_arready;
    assign r_hs          = m_axi_rready && m_axi_rvalid;

    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = ARSIZE;
    assign m_axi_arburst = 2'b01;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        left_d   = left_q;
        arlen_d  = arlen_q;
        acc_d    = acc_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;

        if (tvalid_q && m_axis_tready) tvalid_d = 1'b0;
        if (r_hs) begin
            tdata_d  = m_axi_rdata;
            tvalid_d = 1'b1;
            tlast_d  = m_axi_rlast && (left_q == '0);
            acc_d    = acc_q | (m_axi_rresp != 2'b00);
        end

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_addr_al;
                    left_d = cmd_len;
                    acc_d  = 1'b0;
                    busy_d = 1'b1;
                    if (cmd_len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = ADDR;
                        arlen_d = 8'(calc_blen(cmd_addr_al[11:0], cmd_len) - 9'd1);
                    end
                end
            end
            ADDR: begin
                if (m_axi_arready) begin
                    addr_d  = addr_q + (ADDRESS_SIZE'(blen) << ARSIZE);
                    left_d  = left_q - LEN_SIZE'(blen);
                    state_d = DATA;
                end
            end
            DATA: begin
                if (r_hs && m_axi_rlast) begin
                    if (left_q != '0) begin
                        state_d = ADDR;
                        arlen_d = 8'(calc_blen(addr_q[11:0], left_q) - 9'd1);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!tvalid_q || m_axis_tready) begin
                    done_d  = 1'b1;
                    err_d   = acc_q;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            left_q   <= '0;
            arlen_q  <= '0;
            acc_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            left_q   <= left_d;
            arlen_q  <= arlen_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

`ifdef AXI4_RD_STATS_EN
    logic [31:0] beats_q, bursts_q, stall_q;

    // Beat counter wraps; burst and stall counters saturate.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beats_q  <= '0;
            bursts_q <= '0;
            stall_q  <= '0;
        end else begin
            if (r_hs) beats_q <= beats_q + 32'd1;
            if (ar_hs && (bursts_q != '1)) bursts_q <= bursts_q + 32'd1;
            if ((state_q == DATA) && m_axi_rvalid && !m_axi_rready && (stall_q != '1))
                stall_q <= stall_q + 32'd1;
        end
    end

    assign stat_beats  = beats_q;
    assign stat_bursts = bursts_q;
    assign stat_stall  = stall_q;
`endif

endmodule

// File: tb/tb_axi4_m_burst_reader.sv
// Scoreboard bench for axi4_m_burst_reader: a memory-like AXI slave model, expectation queues and an edge-offset monitor.
module tb_axi4_m_burst_reader;

    logic        aclk, aresetn;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        cmd_valid, cmd_ready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [31:0] tdata;
    logic        tvalid, tlast, tready;
    logic        busy, done, err;

    axi4_m_burst_reader #(
        .ADDRESS_SIZE(32), .DATA_SIZE(32), .MAX_BURST_LEN(16), .LEN_SIZE(16)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize), .m_axi_arburst(arburst),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast), .m_axi_rvalid(rvalid),
        .m_axi_rready(rready),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tlast(tlast), .m_axis_tready(tready),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
    typedef struct { logic [31:0] data; logic last; } beat_t;

    ar_t         exp_ar[$];
    beat_t       exp_beat[$];
    logic        exp_done[$];
    int          total = 0, bad = 0;
    int          done_cnt = 0, ar_cnt = 0, beat_cnt = 0;
    int unsigned cyc = 0, done_cyc = 0, acc_cyc = 0;
    int          ar_delay = 0, err_target = -1, beat_total = 0;
    bit          tready_mode = 0;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Slave model: accepts AR after ar_delay waiting cycles, returns bursts one at a time.
    initial begin
        ar_t         sq[$];
        ar_t         cap;
        logic [31:0] cur_a;
        int          rem, ar_wait;
        bit          hs_ar, hs_r, tog;
        arready = 0; rvalid = 0; rdata = '0; rresp = '0; rlast = 0; tready = 1;
        rem = 0; ar_wait = 0; hs_ar = 0; hs_r = 0; tog = 0; cur_a = '0;
        cap.addr = '0; cap.len = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                sq.delete(); rem = 0; ar_wait = 0; hs_ar = 0; hs_r = 0;
                arready = 0; rvalid = 0; rlast = 0; rresp = '0;
                continue;
            end
            if (hs_ar) sq.push_back(cap);
            if (hs_r) begin rem--; cur_a += 32'd4; beat_total++; end
            if (rem == 0 && sq.size() > 0) begin
                cap = sq.pop_front(); cur_a = cap.addr; rem = int'(cap.len) + 1;
            end
            rvalid = (rem > 0);
            rdata  = mem(cur_a);
            rlast  = (rem == 1);
            rresp  = (rem > 0 && beat_total == err_target) ? 2'b10 : 2'b00;
            if (arvalid && ar_wait >= ar_delay) arready = 1;
            else begin arready = 0; if (arvalid) ar_wait++; end
            tog    = ~tog;
            tready = tready_mode ? tog : 1'b1;
            #1;
            hs_ar = arvalid && arready;
            if (hs_ar) begin cap.addr = araddr; cap.len = arlen; ar_wait = 0; end
            hs_r = rvalid && rready;
        end
    end

    // Monitor: samples mid-cycle, pops expectations on every handshake/done.
    initial begin
        bit          p_arv, p_arr, p_tv, p_tr;
        logic [31:0] p_araddr, p_tdata;
        logic [7:0]  p_arlen;
        logic        p_tlast;
        ar_t         ea;
        beat_t       eb;
        p_arv = 0; p_arr = 0; p_tv = 0; p_tr = 0;
        forever begin
            @(negedge aclk); #2;
            if (!aresetn) begin p_arv = 0; p_tv = 0; continue; end
            if (p_arv && !p_arr) begin
                chk("ar_hold_valid", 64'(arvalid), 64'd1);
                chk("ar_hold_addr", 64'(araddr), 64'(p_araddr));
                chk("ar_hold_len", 64'(arlen), 64'(p_arlen));
            end
            if (p_tv && !p_tr) begin
                chk("t_hold_valid", 64'(tvalid), 64'd1);
                chk("t_hold_data", 64'(tdata), 64'(p_tdata));
                chk("t_hold_last", 64'(tlast), 64'(p_tlast));
            end
            if (tvalid && !tready) chk("rready_when_full", 64'(rready), 64'd0);
            if (arvalid && arready) begin
                ar_cnt++;
                if (exp_ar.size() == 0) chk("ar_unexpected", 64'd1, 64'd0);
                else begin
                    ea = exp_ar.pop_front();
                    chk("araddr", 64'(araddr), 64'(ea.addr));
                    chk("arlen", 64'(arlen), 64'(ea.len));
                    chk("arsize", 64'(arsize), 64'd2);
                    chk("arburst", 64'(arburst), 64'd1);
                end
            end
            if (tvalid && tready) begin
                beat_cnt++;
                if (exp_beat.size() == 0) chk("beat_unexpected", 64'd1, 64'd0);
                else begin
                    eb = exp_beat.pop_front();
                    chk("tdata", 64'(tdata), 64'(eb.data));
                    chk("tlast", 64'(tlast), 64'(eb.last));
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (exp_done.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
                else chk("done_err", 64'(err), 64'(exp_done.pop_front()));
            end
            p_arv = arvalid; p_arr = arready; p_araddr = araddr; p_arlen = arlen;
            p_tv = tvalid; p_tr = tready; p_tdata = tdata; p_tlast = tlast;
        end
    end

    task automatic push_ar(input logic [31:0] a, input logic [7:0] l);
        ar_t e;
        e.addr = a; e.len = l;
        exp_ar.push_back(e);
    endtask

    task automatic push_beats(input logic [31:0] base, input int n);
        beat_t e;
        for (int i = 0; i < n; i++) begin
            e.data = mem(base + 32'(4 * i));
            e.last = (i == n - 1);
            exp_beat.push_back(e);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [15:0] l);
        int n;
        n = 0;
        @(negedge aclk);
        cmd_addr = a; cmd_len = l; cmd_valid = 1;
        #1;
        while (!cmd_ready && n < 100) begin @(negedge aclk); #1; n++; end
        if (!cmd_ready) chk("cmd_accept_timeout", 64'd1, 64'd0);
        acc_cyc = cyc;
        @(negedge aclk);
        cmd_valid = 0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 3000) begin @(negedge aclk); n++; end
        if (done_cnt < target) chk("done_timeout", 64'd1, 64'd0);
        repeat (3) @(negedge aclk);
        chk("ar_queue_drained", 64'(exp_ar.size()), 64'd0);
        chk("beat_queue_drained", 64'(exp_beat.size()), 64'd0);
        chk("done_queue_drained", 64'(exp_done.size()), 64'd0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_araddr", 64'(araddr), 64'd0);
        chk("rst_arlen", 64'(arlen), 64'd0);
        chk("rst_rready", 64'(rready), 64'd0);
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_tdata", 64'(tdata), 64'd0);
        chk("rst_tlast", 64'(tlast), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
    endtask

    initial begin
        int n, d0, a0;
        aresetn = 0; cmd_valid = 0; cmd_addr = '0; cmd_len = '0;
        repeat (3) @(negedge aclk);
        #1 check_reset_outputs();
        @(negedge aclk);
        aresetn = 1;
        repeat (2) @(negedge aclk);

        // Single beat, also checks busy while in flight.
        push_ar(32'h100, 8'd0); push_beats(32'h100, 1); exp_done.push_back(1'b0);
        issue(32'h100, 16'd1);
        chk("busy_in_flight", 64'(busy), 64'd1);
        wait_done(1);

        // Unaligned start: low two address bits dropped.
        push_ar(32'h108, 8'd1); push_beats(32'h108, 2); exp_done.push_back(1'b0);
        issue(32'h10B, 16'd2);
        wait_done(2);

        // 40 beats split 16/16/8.
        push_ar(32'h0, 8'd15); push_ar(32'h40, 8'd15); push_ar(32'h80, 8'd7);
        push_beats(32'h0, 40); exp_done.push_back(1'b0);
        issue(32'h0, 16'd40);
        wait_done(3);

        // 4 KB boundary split.
        push_ar(32'hFF8, 8'd1); push_ar(32'h1000, 8'd1);
        push_beats(32'hFF8, 4); exp_done.push_back(1'b0);
        issue(32'hFF8, 16'd4);
        wait_done(4);

        // Backpressure on both channels.
        tready_mode = 1; ar_delay = 5;
        push_ar(32'h300, 8'd15); push_ar(32'h340, 8'd3);
        push_beats(32'h300, 20); exp_done.push_back(1'b0);
        issue(32'h300, 16'd20);
        wait_done(5);
        tready_mode = 0; ar_delay = 0;

        // Third beat returns SLVERR; the next clean command clears err.
        err_target = beat_total + 2;
        push_ar(32'h400, 8'd7); push_beats(32'h400, 8); exp_done.push_back(1'b1);
        issue(32'h400, 16'd8);
        wait_done(6);
        err_target = -1;
        push_ar(32'h500, 8'd1); push_beats(32'h500, 2); exp_done.push_back(1'b0);
        issue(32'h500, 16'd2);
        wait_done(7);

        // Zero-length command: done two cycles after accept, no AR traffic.
        a0 = ar_cnt;
        exp_done.push_back(1'b0);
        issue(32'h800, 16'd0);
        wait_done(8);
        chk("len0_done_latency", 64'(done_cyc - acc_cyc), 64'd2);
        chk("len0_no_ar", 64'(ar_cnt - a0), 64'd0);

        // Asynchronous reset mid-burst.
        push_ar(32'h600, 8'd15); push_beats(32'h600, 16);
        d0 = done_cnt; n = beat_cnt;
        issue(32'h600, 16'd16);
        a0 = 0;
        while (beat_cnt < n + 5 && a0 < 200) begin @(negedge aclk); a0++; end
        if (beat_cnt < n + 5) chk("reset_test_progress", 64'd1, 64'd0);
        @(negedge aclk);
        aresetn = 0;
        exp_ar.delete(); exp_beat.delete();
        #1 check_reset_outputs();
        repeat (2) @(negedge aclk);
        aresetn = 1;
        repeat (5) @(negedge aclk);
        chk("no_done_after_reset", 64'(done_cnt), 64'(d0));

        // Recovery after reset.
        push_ar(32'h700, 8'd2); push_beats(32'h700, 3); exp_done.push_back(1'b0);
        issue(32'h700, 16'd3);
        wait_done(d0 + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
